// File: rtl/fifo_1_to_n_pkg.sv
// Shared helpers for fifo_1_to_n: capacity and count widths, lane offsets,
// and the debug counter record.
package fifo_1_to_n_pkg;

  localparam int DBG_W = 32;

  function automatic int cap_of(input int depth);
    return 1 << depth;
  endfunction

  function automatic int cnt_w(input int depth);
    return depth + 1;
  endfunction

  function automatic int lane_lo(input int k, input int lane_w);
    return k * lane_w;
  endfunction

  typedef struct packed {
    logic [DBG_W-1:0] trial;
    logic [DBG_W-1:0] count;
    logic [DBG_W-1:0] fail;
  } dbg_cnt_t;

endpackage

// File: rtl/fifo_1_to_n_lane_ram.sv
// One lane of FIFO storage: CAP x LANE_W, synchronous write, asynchronous read.
// Contents are deliberately not reset; the pointers define what is valid.
module fifo_1_to_n_lane_ram
  import fifo_1_to_n_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int DEPTH  = 5
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [DEPTH-1:0]  i_wr_addr,
  input  logic [LANE_W-1:0] i_wr_data,
  input  logic [DEPTH-1:0]  i_rd_addr,
  output logic [LANE_W-1:0] o_rd_data
);

  localparam int CAP = cap_of(DEPTH);

  logic [LANE_W-1:0] mem [CAP];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/fifo_1_to_n.sv
// Single-clock FIFO taking N*LANE_W-bit words and presenting them as N lanes
// with show-ahead read, occupancy flags/counts and optional debug counters.
module fifo_1_to_n
  import fifo_1_to_n_pkg::*;
#(
  parameter int N          = 8,
  parameter int LANE_W     = 8,
  parameter int DEPTH      = 5,
  parameter int PFULL_TH   = 8,
  parameter int PEMPTY_TH  = 8,
  parameter int DEBUG_MODE = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_wr_en,
  input  logic [N*LANE_W-1:0]     i_wr_data,
  output logic                    o_wr_full,
  output logic                    o_wr_afull,
  output logic                    o_wr_pfull,
  output logic [DEPTH:0]          o_wr_remain,
  input  logic                    i_rd_en,
  output logic [N*LANE_W-1:0]     o_rd_data,
  output logic                    o_rd_empty,
  output logic                    o_rd_aempty,
  output logic                    o_rd_pempty,
  output logic [DEPTH:0]          o_rd_depth,
  output logic [DBG_W-1:0]        o_wr_trial,
  output logic [DBG_W-1:0]        o_wr_count,
  output logic [DBG_W-1:0]        o_wr_fail,
  output logic [DBG_W-1:0]        o_rd_trial,
  output logic [DBG_W-1:0]        o_rd_count,
  output logic [DBG_W-1:0]        o_rd_fail
);

  localparam int WIDTH = N * LANE_W;
  localparam int CW    = cnt_w(DEPTH);
  localparam logic [CW-1:0] CAP_V = CW'(cap_of(DEPTH));

  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    depth;
  logic [CW-1:0]    remain;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] head_word;

  assign depth  = wr_ptr - rd_ptr;
  assign remain = CAP_V - depth;

  assign o_rd_depth  = depth;
  assign o_wr_remain = remain;
  assign o_wr_full   = (remain == '0);
  assign o_wr_afull  = (remain <= CW'(1));
  assign o_wr_pfull  = (32'(remain) <= 32'(PFULL_TH));
  assign o_rd_empty  = (depth == '0);
  assign o_rd_aempty = (depth <= CW'(1));
  assign o_rd_pempty = (32'(depth) <= 32'(PEMPTY_TH));

  assign wr_acc = i_wr_en & ~o_wr_full;
  assign rd_acc = i_rd_en & ~o_rd_empty;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    fifo_1_to_n_lane_ram #(
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (wr_acc),
      .i_wr_addr (wr_ptr[DEPTH-1:0]),
      .i_wr_data (i_wr_data[lane_lo(k, LANE_W) +: LANE_W]),
      .i_rd_addr (rd_ptr[DEPTH-1:0]),
      .o_rd_data (head_word[lane_lo(k, LANE_W) +: LANE_W])
    );
  end

  // Stale storage is masked so an empty FIFO always presents zero.
  assign o_rd_data = o_rd_empty ? '0 : head_word;

  dbg_cnt_t wr_dbg;
  dbg_cnt_t rd_dbg;

  if (DEBUG_MODE == 1) begin : g_dbg
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        wr_dbg <= '0;
        rd_dbg <= '0;
      end else begin
        wr_dbg.trial <= wr_dbg.trial + DBG_W'(i_wr_en);
        wr_dbg.count <= wr_dbg.count + DBG_W'(wr_acc);
        wr_dbg.fail  <= wr_dbg.fail  + DBG_W'(i_wr_en & o_wr_full);
        rd_dbg.trial <= rd_dbg.trial + DBG_W'(i_rd_en);
        rd_dbg.count <= rd_dbg.count + DBG_W'(rd_acc);
        rd_dbg.fail  <= rd_dbg.fail  + DBG_W'(i_rd_en & o_rd_empty);
      end
    end
  end else begin : g_no_dbg
    assign wr_dbg = '0;
    assign rd_dbg = '0;
  end

  assign o_wr_trial = wr_dbg.trial;
  assign o_wr_count = wr_dbg.count;
  assign o_wr_fail  = wr_dbg.fail;
  assign o_rd_trial = rd_dbg.trial;
  assign o_rd_count = rd_dbg.count;
  assign o_rd_fail  = rd_dbg.fail;

endmodule

// File: tb/tb_fifo_1_to_n.sv
// Self-checking bench for fifo_1_to_n: directed boundary cases plus random
// traffic, scored against a queue-based reference model.
module tb_fifo_1_to_n;

  localparam int N      = 8;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 5;
  localparam int WIDTH  = N * LANE_W;
  localparam int CAP    = 32;
  localparam int PF_TH  = 8;
  localparam int PE_TH  = 8;

  logic             i_clk;
  logic             i_rstn;
  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_wr_full, o_wr_afull, o_wr_pfull;
  logic [DEPTH:0]   o_wr_remain;
  logic             i_rd_en;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_empty, o_rd_aempty, o_rd_pempty;
  logic [DEPTH:0]   o_rd_depth;
  logic [31:0]      o_wr_trial, o_wr_count, o_wr_fail;
  logic [31:0]      o_rd_trial, o_rd_count, o_rd_fail;

  fifo_1_to_n #(
    .N(N), .LANE_W(LANE_W), .DEPTH(DEPTH),
    .PFULL_TH(PF_TH), .PEMPTY_TH(PE_TH), .DEBUG_MODE(1)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_wr_full(o_wr_full), .o_wr_afull(o_wr_afull), .o_wr_pfull(o_wr_pfull),
    .o_wr_remain(o_wr_remain),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
    .o_rd_empty(o_rd_empty), .o_rd_aempty(o_rd_aempty), .o_rd_pempty(o_rd_pempty),
    .o_rd_depth(o_rd_depth),
    .o_wr_trial(o_wr_trial), .o_wr_count(o_wr_count), .o_wr_fail(o_wr_fail),
    .o_rd_trial(o_rd_trial), .o_rd_count(o_rd_count), .o_rd_fail(o_rd_fail)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the stored words in order plus plain request tallies.
  logic [WIDTH-1:0] sb [$];
  int unsigned m_wr_trial, m_wr_count, m_wr_fail;
  int unsigned m_rd_trial, m_rd_count, m_rd_fail;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and take effect on the next one.
  task automatic apply_stimulus(input logic wr, input logic [WIDTH-1:0] data, input logic rd);
    @(posedge i_clk);
    #1;
    i_wr_en   = wr;
    i_wr_data = data;
    i_rd_en   = rd;
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Monitor: on every falling edge compare the DUT to the model, then advance
  // the model by the request that the coming rising edge will see.
  always @(negedge i_clk) begin
    int  d;
    bit  wa, ra;
    if (!i_rstn) begin
      sb.delete();
      m_wr_trial = 0; m_wr_count = 0; m_wr_fail = 0;
      m_rd_trial = 0; m_rd_count = 0; m_rd_fail = 0;
    end else begin
      d = sb.size();
      check_output("depth",  64'(o_rd_depth),  64'(d));
      check_output("remain", 64'(o_wr_remain), 64'(CAP - d));
      check_output("empty",  64'(o_rd_empty),  64'(d == 0));
      check_output("aempty", 64'(o_rd_aempty), 64'(d <= 1));
      check_output("pempty", 64'(o_rd_pempty), 64'(d <= PE_TH));
      check_output("full",   64'(o_wr_full),   64'(d == CAP));
      check_output("afull",  64'(o_wr_afull),  64'(CAP - d <= 1));
      check_output("pfull",  64'(o_wr_pfull),  64'(CAP - d <= PF_TH));
      check_output("rd_data", o_rd_data, (d > 0) ? sb[0] : 64'h0);
      check_output("wr_trial", 64'(o_wr_trial), 64'(m_wr_trial));
      check_output("wr_count", 64'(o_wr_count), 64'(m_wr_count));
      check_output("wr_fail",  64'(o_wr_fail),  64'(m_wr_fail));
      check_output("rd_trial", 64'(o_rd_trial), 64'(m_rd_trial));
      check_output("rd_count", 64'(o_rd_count), 64'(m_rd_count));
      check_output("rd_fail",  64'(o_rd_fail),  64'(m_rd_fail));
      check_output("wr_sum", 64'(o_wr_trial), 64'(o_wr_count) + 64'(o_wr_fail));
      check_output("rd_sum", 64'(o_rd_trial), 64'(o_rd_count) + 64'(o_rd_fail));

      wa = i_wr_en && (d < CAP);
      ra = i_rd_en && (d > 0);
      if (i_wr_en) m_wr_trial++;
      if (wa)      m_wr_count++;
      if (i_wr_en && !wa) m_wr_fail++;
      if (i_rd_en) m_rd_trial++;
      if (ra)      m_rd_count++;
      if (i_rd_en && !ra) m_rd_fail++;
      if (ra) void'(sb.pop_front());
      if (wa) sb.push_back(i_wr_data);
    end
  end

  initial begin
    logic [WIDTH-1:0] lane_word;
    logic [WIDTH-1:0] post_word;
    int wp, rp;

    i_rstn = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_wr_data = '0;
    #2;
    // Reset values.
    check_output("rst_empty",  64'(o_rd_empty),  64'd1);
    check_output("rst_aempty", 64'(o_rd_aempty), 64'd1);
    check_output("rst_pempty", 64'(o_rd_pempty), 64'd1);
    check_output("rst_full",   64'(o_wr_full),   64'd0);
    check_output("rst_afull",  64'(o_wr_afull),  64'd0);
    check_output("rst_pfull",  64'(o_wr_pfull),  64'd0);
    check_output("rst_remain", 64'(o_wr_remain), 64'd32);
    check_output("rst_depth",  64'(o_rd_depth),  64'd0);
    check_output("rst_data",   o_rd_data,        64'd0);
    check_output("rst_wr_trial", 64'(o_wr_trial), 64'd0);
    check_output("rst_rd_count", 64'(o_rd_count), 64'd0);
    @(posedge i_clk); #1; i_rstn = 1'b1;

    // Lane mapping: lane k must carry value k.
    lane_word = 64'h0706050403020100;
    apply_stimulus(1'b1, lane_word, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    for (int k = 0; k < N; k++)
      check_output($sformatf("lane%0d", k), 64'(o_rd_data[k*LANE_W +: LANE_W]), 64'(k));
    apply_stimulus(1'b0, '0, 1'b1);

    // Fill to capacity, then one rejected write.
    for (int i = 0; i < CAP; i++) apply_stimulus(1'b1, rand_word(), 1'b0);
    apply_stimulus(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    check_output("fill_full",   64'(o_wr_full),   64'd1);
    check_output("fill_afull",  64'(o_wr_afull),  64'd1);
    check_output("fill_pfull",  64'(o_wr_pfull),  64'd1);
    check_output("fill_remain", 64'(o_wr_remain), 64'd0);
    check_output("fill_depth",  64'(o_rd_depth),  64'd32);
    check_output("fill_wr_fail", 64'(o_wr_fail),  64'd1);

    // Read and write together while full: only the read is accepted.
    apply_stimulus(1'b1, rand_word(), 1'b1);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    check_output("full_rw_depth", 64'(o_rd_depth), 64'd31);

    // Refill, then drain 10.
    apply_stimulus(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    check_output("drain_full",   64'(o_wr_full),   64'd0);
    check_output("drain_depth",  64'(o_rd_depth),  64'd22);
    check_output("drain_remain", 64'(o_wr_remain), 64'd10);

    // Drain to empty, then read and write together: only the write is accepted.
    for (int i = 0; i < 22; i++) apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b1, rand_word(), 1'b1);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    check_output("empty_rw_depth", 64'(o_rd_depth), 64'd1);
    apply_stimulus(1'b0, '0, 1'b1);

    // Random traffic in phases with different write/read biases.
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 4)
        0: begin wp = 80; rp = 20; end
        1: begin wp = 20; rp = 80; end
        2: begin wp = 50; rp = 50; end
        default: begin wp = 95; rp = 95; end
      endcase
      apply_stimulus($urandom_range(99) < wp, rand_word(), $urandom_range(99) < rp);
    end

    // Drain, load 17 words, then reset asynchronously mid-stream.
    for (int i = 0; i < CAP + 1; i++) apply_stimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 17; i++) apply_stimulus(1'b1, rand_word(), 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    check_output("pre_rst_depth", 64'(o_rd_depth), 64'd17);
    @(posedge i_clk);
    #3;
    i_rstn = 1'b0;
    #1;
    check_output("mid_rst_empty",   64'(o_rd_empty), 64'd1);
    check_output("mid_rst_depth",   64'(o_rd_depth), 64'd0);
    check_output("mid_rst_data",    o_rd_data,       64'd0);
    check_output("mid_rst_wr_count", 64'(o_wr_count), 64'd0);
    check_output("mid_rst_rd_trial", 64'(o_rd_trial), 64'd0);
    @(posedge i_clk); #1; i_rstn = 1'b1;
    post_word = 64'h1234_5678_9ABC_DEF0;
    apply_stimulus(1'b1, post_word, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    check_output("post_rst_head", o_rd_data, post_word);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge i_clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
